// File: rtl/i2c_burst_seq.sv
// i2c_burst_seq: I2C write sequencer streaming command then display ROM bytes to an SSD1306-class slave
// Ports:
//   clk2            system clock
//   reset           asynchronous active-low reset; releases both bus lines at once
//   start           single-cycle pulse, starts a sequence when idle
//   data            ROM byte for {phase,address}, valid one clk2 after address changes
//   sda_in, scl_in  synchronised pad levels
//   address, phase  ROM index and ROM select (0 = command, 1 = display)
//   sda_oe, scl_oe  open-drain pull-low enables
//   busy, done, error  sequence status; done/error held until the next start
module i2c_burst_seq #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         ADDR_W     = 10,
    parameter int         CMD_COUNT  = 41,
    parameter int         DATA_COUNT = 1024,
    parameter int         BURST_LEN  = 16,
    parameter logic [7:0] CTRL_CMD   = 8'h00,
    parameter logic [7:0] CTRL_DATA  = 8'h40,
    parameter int         MAX_RETRY  = 3
) (
    input  logic              clk2,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        data,
    input  logic              sda_in,
    input  logic              scl_in,
    output logic [ADDR_W-1:0] address,
    output logic              phase,
    output logic              sda_oe,
    output logic              scl_oe,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_ADDR = 3'd2, S_CTRL = 3'd3,
                           S_BYTE = 3'd4, S_STOP = 3'd5, S_DONE = 3'd6, S_ERR = 3'd7;
    logic [2:0]      state;
    logic [DW-1:0]   div;
    logic [1:0]      q;
    logic [3:0]      bcnt;
    logic [7:0]      sh;
    logic [BW-1:0]   burst;
    logic [RW-1:0]   retry;
    logic            nack, fin, run, bit_st, ack_bit, hold, tick, cont;
    logic [ADDR_W:0] nxt_addr, limit;
    assign run      = state inside {S_START, S_ADDR, S_CTRL, S_BYTE, S_STOP};
    assign bit_st   = state inside {S_ADDR, S_CTRL, S_BYTE};
    // bcnt == 8 is the ninth (acknowledge) bit of a byte
    assign ack_bit  = bcnt == 4'd8;
    // slave clock stretching: freeze the divider while SCL is held low in Q2
    assign hold     = bit_st && q == 2'd2 && !scl_in;
    assign tick     = run && !hold && div == DW'(CLK_DIV - 1);
    assign nxt_addr = {1'b0, address} + (ADDR_W + 1)'(1);
    assign limit    = phase ? (ADDR_W + 1)'(DATA_COUNT) : (ADDR_W + 1)'(CMD_COUNT);
    // fin marks that the last byte of the current ROM has been acknowledged
    assign cont     = phase && burst < BW'(BURST_LEN) && !fin;
    assign scl_oe   = bit_st ? !q[1] : state == S_STOP && q == 2'd0;
    assign sda_oe   = state == S_START ? q[1] :
                      state == S_STOP  ? !q[1] :
                      bit_st && !ack_bit && !sh[7];
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            div     <= '0;
            q       <= '0;
            bcnt    <= '0;
            sh      <= '0;
            burst   <= '0;
            retry   <= '0;
            nack    <= 1'b0;
            fin     <= 1'b0;
            address <= '0;
            phase   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            div <= (!run || tick || hold) ? '0 : div + DW'(1);
            if (tick) q <= q + 2'd1;
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_START;
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    error   <= 1'b0;
                    address <= '0;
                    phase   <= 1'b0;
                    retry   <= '0;
                    fin     <= 1'b0;
                    q       <= '0;
                end
                S_START: if (tick && q == 2'd3) begin
                    state <= S_ADDR;
                    bcnt  <= '0;
                    sh    <= {SLAVE_ADDR, 1'b0};
                    burst <= '0;
                    nack  <= 1'b0;
                end
                S_ADDR, S_CTRL, S_BYTE: if (tick) begin
                    // acknowledge is resolved at the end of Q2 so the new address
                    // settles a full quarter before the next byte is latched
                    if (q == 2'd2 && ack_bit) begin
                        nack <= sda_in;
                        if (sda_in) retry <= retry + RW'(1);
                        else if (state == S_BYTE) begin
                            address <= nxt_addr[ADDR_W-1:0];
                            burst   <= burst + BW'(1);
                            retry   <= '0;
                            fin     <= nxt_addr == limit;
                        end
                    end
                    if (q == 2'd3) begin
                        bcnt <= ack_bit ? 4'd0 : bcnt + 4'd1;
                        sh   <= !ack_bit ? {sh[6:0], 1'b0} :
                                state == S_ADDR ? (phase ? CTRL_DATA : CTRL_CMD) : data;
                        if (ack_bit)
                            state <= nack ? S_STOP :
                                     state == S_ADDR ? S_CTRL :
                                     state == S_CTRL ? S_BYTE :
                                     cont ? S_BYTE : S_STOP;
                    end
                end
                S_STOP: if (tick && q == 2'd3) begin
                    if (nack) state <= retry > RW'(MAX_RETRY) ? S_ERR : S_START;
                    else if (fin && phase) state <= S_DONE;
                    else begin
                        state <= S_START;
                        if (fin) begin
                            phase   <= 1'b1;
                            address <= '0;
                            fin     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
